// File: rtl/periodic_serial_tx.sv
`default_nettype none
// ============================================================================
// Module  : periodic_serial_tx
// Brief   : Periodic serial frame transmitter with a programmable standby gap
// Revision: 1.0
// ============================================================================
module periodic_serial_tx #(
  parameter int MSG_W     = 4,
  parameter int SB_W      = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [MSG_W-1:0] msg,
  input  logic [SB_W-1:0]  SB,
  output logic             state_send,
  output logic             state_out,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;

  localparam logic [1:0]       C_IDLE     = 2'd0;
  localparam logic [1:0]       C_SEND     = 2'd1;
  localparam logic [1:0]       C_GAP      = 2'd2;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(MSG_W - 1);
  localparam logic [SB_W-1:0]  C_GAP_ONE  = SB_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SB_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [MSG_W-1:0] shreg_q, shreg_d;
  logic             state_send_q, state_send_d;
  logic             state_out_q, state_out_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  logic             load;
  logic             first_bit;
  logic             next_bit;
  logic [MSG_W-1:0] shreg_shifted;

  // The bit on state_out is always the head of the shift register.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign first_bit     = msg[MSG_W-1];
      assign next_bit      = shreg_q[MSG_W-2];
      assign shreg_shifted = shreg_q << 1;
    end else begin : g_lsb_first
      assign first_bit     = msg[0];
      assign next_bit      = shreg_q[1];
      assign shreg_shifted = shreg_q >> 1;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    shreg_d      = shreg_q;
    state_out_d  = 1'b0;
    frame_done_d = 1'b0;
    load         = 1'b0;

    case (state_q)
      C_IDLE: begin
        if (EN) load = 1'b1;
      end
      C_SEND: begin
        if (bit_cnt_q == C_LAST_BIT) begin
          frame_done_d = 1'b1;
          if (!EN) begin
            state_d = C_IDLE;
          end else if (SB == '0) begin
            load = 1'b1;
          end else begin
            state_d   = C_GAP;
            gap_cnt_d = SB;
          end
        end else begin
          bit_cnt_d   = bit_cnt_q + 1'b1;
          shreg_d     = shreg_shifted;
          state_out_d = next_bit;
        end
      end
      C_GAP: begin
        // Counting down to one, not zero, keeps a full-scale SB from wrapping.
        if (!EN) begin
          state_d   = C_IDLE;
          gap_cnt_d = '0;
        end else if (gap_cnt_q == C_GAP_ONE) begin
          load = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = C_IDLE;
      end
    endcase

    if (load) begin
      state_d     = C_SEND;
      shreg_d     = msg;
      bit_cnt_d   = '0;
      gap_cnt_d   = '0;
      state_out_d = first_bit;
    end

    state_send_d = (state_d == C_SEND);
    busy_d       = (state_d != C_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= C_IDLE;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      shreg_q      <= '0;
      state_send_q <= 1'b0;
      state_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      shreg_q      <= shreg_d;
      state_send_q <= state_send_d;
      state_out_q  <= state_out_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign state_send = state_send_q;
  assign state_out  = state_out_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_periodic_serial_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_periodic_serial_tx
// Brief   : Self-checking bench for periodic_serial_tx (LSB-first and MSB-first)
// Revision: 1.0
// ============================================================================
module tb_periodic_serial_tx;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic [3:0] msg;
  logic [3:0] SB;

  logic send_l, out_l, fd_l, busy_l;
  logic send_m, out_m, fd_m, busy_m;

  int checks   = 0;
  int failures = 0;

  // Expected per-cycle tuple {state_send, state_out, frame_done, busy}
  logic [3:0] exp_q[$];

  typedef struct {
    logic [3:0] msg_a;   // message presented at the first start edge
    logic [3:0] msg_b;   // message presented from the next edge onward
    logic [3:0] sb;
    int         frames;
    logic [3:0] exp_a;   // bits of frame 0 in send order, first bit in [3]
    logic [3:0] exp_b;   // bits of later frames in send order
    bit         msb;     // check the MSB-first instance
  } vec_t;

  vec_t vecs[6];

  periodic_serial_tx #(.MSG_W(4), .SB_W(4), .MSB_FIRST(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .msg(msg), .SB(SB),
    .state_send(send_l), .state_out(out_l), .frame_done(fd_l), .busy(busy_l)
  );

  periodic_serial_tx #(.MSG_W(4), .SB_W(4), .MSB_FIRST(1)) dut_m (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .msg(msg), .SB(SB),
    .state_send(send_m), .state_out(out_m), .frame_done(fd_m), .busy(busy_m)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual={send,out,fd,busy}=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [3:0] bits, input bit fd_first);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({1'b1, bits[3-i], (i == 0) ? fd_first : 1'b0, 1'b1});
  endtask

  // Applies stimulus edge by edge and pops one expectation per cycle.
  task automatic run(input string name, input logic [3:0] msg_a, input logic [3:0] msg_b,
                     input logic [3:0] sb, input int en_last, input bit use_m);
    int c;
    logic [3:0] e;
    logic [3:0] a;
    c = 0;
    while (exp_q.size() > 0) begin
      EN  = (c <= en_last);
      msg = (c == 0) ? msg_a : msg_b;
      SB  = sb;
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      a = use_m ? {send_m, out_m, fd_m, busy_m} : {send_l, out_l, fd_l, busy_l};
      chk($sformatf("%s_c%0d", name, c), a, e);
      c++;
    end
  endtask

  initial begin
    vecs[0] = '{msg_a: 4'b1011, msg_b: 4'b1011, sb: 4'd3,  frames: 3, exp_a: 4'b1101, exp_b: 4'b1101, msb: 1'b0};
    vecs[1] = '{msg_a: 4'b0110, msg_b: 4'b0110, sb: 4'd0,  frames: 3, exp_a: 4'b0110, exp_b: 4'b0110, msb: 1'b0};
    vecs[2] = '{msg_a: 4'b1011, msg_b: 4'b0001, sb: 4'd2,  frames: 2, exp_a: 4'b1101, exp_b: 4'b1000, msb: 1'b0};
    vecs[3] = '{msg_a: 4'b1100, msg_b: 4'b0011, sb: 4'd0,  frames: 2, exp_a: 4'b0011, exp_b: 4'b1100, msb: 1'b0};
    vecs[4] = '{msg_a: 4'b0101, msg_b: 4'b0101, sb: 4'd15, frames: 2, exp_a: 4'b1010, exp_b: 4'b1010, msb: 1'b0};
    vecs[5] = '{msg_a: 4'b1000, msg_b: 4'b1000, sb: 4'd15, frames: 2, exp_a: 4'b1000, exp_b: 4'b1000, msb: 1'b1};

    RST_N = 1'b0;
    EN    = 1'b0;
    msg   = 4'b0;
    SB    = 4'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_l", {send_l, out_l, fd_l, busy_l}, 4'b0000);
    chk("reset_m", {send_m, out_m, fd_m, busy_m}, 4'b0000);
    @(negedge CLK);
    RST_N = 1'b1;

    repeat (2) exp_q.push_back(4'b0000);
    run("idle_en0", 4'b1111, 4'b1111, 4'd0, -1, 1'b0);

    foreach (vecs[k]) begin
      for (int f = 0; f < vecs[k].frames; f++) begin
        push_frame((f == 0) ? vecs[k].exp_a : vecs[k].exp_b, (f > 0) && (vecs[k].sb == 4'd0));
        if (f < vecs[k].frames - 1)
          for (int g = 0; g < int'(vecs[k].sb); g++)
            exp_q.push_back({1'b0, 1'b0, (g == 0), 1'b1});
      end
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0000);
      // EN drops right after the last frame starts; that frame must still complete.
      run($sformatf("vec%0d", k), vecs[k].msg_a, vecs[k].msg_b, vecs[k].sb,
          (vecs[k].frames - 1) * (4 + int'(vecs[k].sb)), vecs[k].msb);
    end

    // EN drops in the first gap cycle: IDLE next cycle, no further frame.
    push_frame(4'b1101, 1'b0);
    exp_q.push_back(4'b0011);
    repeat (5) exp_q.push_back(4'b0000);
    run("gap_drop", 4'b1011, 4'b1011, 4'd3, 4, 1'b0);

    // Asynchronous reset between edges in the middle of a frame.
    EN  = 1'b1;
    msg = 4'b1011;
    SB  = 4'd3;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("pre_rst_bit1", {send_l, out_l, fd_l, busy_l}, 4'b1101);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst", {send_l, out_l, fd_l, busy_l}, 4'b0000);
    @(posedge CLK);
    #1;
    chk("rst_hold", {send_l, out_l, fd_l, busy_l}, 4'b0000);
    @(negedge CLK);
    RST_N = 1'b1;
    push_frame(4'b1101, 1'b0);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0000);
    run("post_rst", 4'b1011, 4'b1011, 4'd3, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
